// File: rtl/mux_arbiter_4_if.sv
// Request/data/grant bundle between four requesters and the round-robin mux arbiter.
// The master side drives requests, data and Ack; the slave side is the arbiter.
interface mux_arbiter_4_if #(
   parameter int WIDTH = 32
);
   logic [3:0]       Req;
   logic [WIDTH-1:0] InA;
   logic [WIDTH-1:0] InB;
   logic [WIDTH-1:0] InC;
   logic [WIDTH-1:0] InD;
   logic             Ack;
   logic [WIDTH-1:0] Out;
   logic [1:0]       Sel;
   logic [3:0]       Grant;
   logic             Valid;
   logic             Timeout;

   modport master (
      output Req, InA, InB, InC, InD, Ack,
      input  Out, Sel, Grant, Valid, Timeout
   );

   modport slave (
      input  Req, InA, InB, InC, InD, Ack,
      output Out, Sel, Grant, Valid, Timeout
   );
endinterface

// File: rtl/mux_arbiter_4.sv
// Four-way round-robin arbiter with a registered data mux, hold-time limit and timeout flag.
// Grant, Sel and Out are updated on the same edge so downstream sees a consistent owner/data pair.
module mux_arbiter_4 #(
   parameter int WIDTH    = 32,
   parameter int MAX_HOLD = 15
) (
   input logic           Clk,
   input logic           Reset,
   mux_arbiter_4_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [3:0]       hold_q, hold_d;
   logic [3:0]       grant_q, grant_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             timeout_q, timeout_d;

   logic [1:0]       win_idle;
   logic [1:0]       win_rel;
   logic             rel_ack;
   logic             rel_abandon;
   logic             rel_timeout;

   // First requester at or above base, wrapping modulo 4.
   function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] base);
      logic [1:0] idx;
      pick = base;
      for (int k = 3; k >= 0; k--) begin
         idx = base + 2'(k);
         if (req[idx]) pick = idx;
      end
   endfunction

   function automatic logic [WIDTH-1:0] data_of(input logic [1:0] idx,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] c,
                                                input logic [WIDTH-1:0] d);
      case (idx)
         2'd0:    data_of = a;
         2'd1:    data_of = b;
         2'd2:    data_of = c;
         default: data_of = d;
      endcase
   endfunction

   assign win_idle    = pick(bus.Req, ptr_q);
   assign win_rel     = pick(bus.Req, sel_q + 2'd1);

   // Ack wins over everything; a dropped owner request is an abandon even at the hold limit.
   assign rel_ack     = bus.Ack;
   assign rel_abandon = !bus.Ack && !bus.Req[sel_q];
   assign rel_timeout = !bus.Ack && bus.Req[sel_q] && (hold_q >= HOLD_MAX);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      sel_d     = sel_q;
      out_d     = out_q;
      timeout_d = 1'b0;

      case (state_q)
         IDLE: begin
            grant_d = 4'b0000;
            if (bus.Req != 4'b0000) begin
               state_d = BUSY;
               sel_d   = win_idle;
               grant_d = 4'b0001 << win_idle;
               hold_d  = 4'd1;
               out_d   = data_of(win_idle, bus.InA, bus.InB, bus.InC, bus.InD);
            end
         end

         BUSY: begin
            if (rel_ack || rel_abandon || rel_timeout) begin
               ptr_d     = sel_q + 2'd1;
               timeout_d = rel_timeout;
               if (bus.Req != 4'b0000) begin
                  state_d = BUSY;
                  sel_d   = win_rel;
                  grant_d = 4'b0001 << win_rel;
                  hold_d  = 4'd1;
                  out_d   = data_of(win_rel, bus.InA, bus.InB, bus.InC, bus.InD);
               end else begin
                  state_d = IDLE;
                  grant_d = 4'b0000;
               end
            end else begin
               hold_d = hold_q + 4'd1;
               out_d  = data_of(sel_q, bus.InA, bus.InB, bus.InC, bus.InD);
            end
         end

         default: begin
            state_d = IDLE;
            grant_d = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         ptr_q     <= 2'd0;
         hold_q    <= 4'd0;
         grant_q   <= 4'b0000;
         sel_q     <= 2'd0;
         out_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         sel_q     <= sel_d;
         out_q     <= out_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.Out     = out_q;
   assign bus.Sel     = sel_q;
   assign bus.Grant   = grant_q;
   assign bus.Valid   = (state_q == BUSY);
   assign bus.Timeout = timeout_q;

endmodule

// File: tb/tb_mux_arbiter_4.sv
// Directed bench for mux_arbiter_4: reset, single grant, round robin, timeout, Ack at the limit,
// abandon, mid-grant reset and non-owner request changes, all with hand-computed expectations.
module tb_mux_arbiter_4;

   logic Clk;
   logic Reset;
   int   n_cmp;
   int   n_fail;

   mux_arbiter_4_if #(.WIDTH(32)) bus ();

   mux_arbiter_4 #(.WIDTH(32), .MAX_HOLD(15)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset   = 1'b1;
      bus.Req = 4'b0000;
      bus.Ack = 1'b0;
      step();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.InA = 32'h1111_1111;
      bus.InB = 32'h2222_2222;
      bus.InC = 32'h3333_3333;
      bus.InD = 32'h4444_4444;
      do_reset();
      n_cmp++;
      if (bus.Grant !== 4'b0000 || bus.Valid !== 1'b0 || bus.Timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl: grant=%b valid=%b timeout=%b, want 0000/0/0", bus.Grant, bus.Valid, bus.Timeout);
      end
      n_cmp++;
      if (bus.Out !== 32'h0 || bus.Sel !== 2'd0 || dut.ptr_q !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_data: out=%h sel=%0d ptr=%0d, want 0/0/0", bus.Out, bus.Sel, dut.ptr_q);
      end
   endtask

   task automatic test_single();
      do_reset();
      bus.InA = 32'hAAAA_0001;
      bus.Req = 4'b0001;
      step();
      n_cmp++;
      if (bus.Grant !== 4'b0001 || bus.Sel !== 2'd0 || bus.Valid !== 1'b1 || bus.Out !== 32'hAAAA_0001) begin
         n_fail++;
         $display("FAIL single_grant: grant=%b sel=%0d valid=%b out=%h, want 0001/0/1/aaaa0001",
                  bus.Grant, bus.Sel, bus.Valid, bus.Out);
      end
      bus.Ack = 1'b1;
      bus.Req = 4'b0000;
      step();
      n_cmp++;
      if (bus.Grant !== 4'b0000 || bus.Valid !== 1'b0 || dut.ptr_q !== 2'd1 || bus.Timeout !== 1'b0
          || bus.Out !== 32'hAAAA_0001) begin
         n_fail++;
         $display("FAIL single_release: grant=%b valid=%b ptr=%0d to=%b out=%h, want 0000/0/1/0/aaaa0001",
                  bus.Grant, bus.Valid, dut.ptr_q, bus.Timeout, bus.Out);
      end
      step();
      n_cmp++;
      if (bus.Grant !== 4'b0000 || bus.Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ack: grant=%b valid=%b, want 0000/0", bus.Grant, bus.Valid);
      end
      bus.Ack = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [31:0] exp_o [5] = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hA0};
      do_reset();
      bus.InA = 32'hA0;
      bus.InB = 32'hB0;
      bus.InC = 32'hC0;
      bus.InD = 32'hD0;
      bus.Req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         bus.Ack = 1'b1;
         n_cmp++;
         if (bus.Grant !== exp_g[i] || bus.Valid !== 1'b1 || bus.Out !== exp_o[i]) begin
            n_fail++;
            $display("FAIL rr_%0d: grant=%b valid=%b out=%h, want %b/1/%h",
                     i, bus.Grant, bus.Valid, bus.Out, exp_g[i], exp_o[i]);
         end
      end
      bus.Req = 4'b0000;
      step();
      bus.Ack = 1'b0;
      n_cmp++;
      if (bus.Grant !== 4'b0000 || dut.ptr_q !== 2'd1) begin
         n_fail++;
         $display("FAIL rr_end: grant=%b ptr=%0d, want 0000/1", bus.Grant, dut.ptr_q);
      end
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      bus.InC = 32'hC0C0_C0C0;
      bus.Req = 4'b0100;
      bus.Ack = 1'b0;
      bad = 0;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (bus.Grant !== 4'b0100 || bus.Timeout !== 1'b0 || bus.Out !== 32'hC0C0_C0C0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL to_hold: %0d bad cycles of 15, want grant 0100 with no timeout", bad);
      end
      // Only C is requesting, so the timeout release re-grants it immediately.
      step();
      n_cmp++;
      if (bus.Timeout !== 1'b1 || dut.ptr_q !== 2'd3 || bus.Grant !== 4'b0100 || dut.hold_q !== 4'd1) begin
         n_fail++;
         $display("FAIL to_release: to=%b ptr=%0d grant=%b hold=%0d, want 1/3/0100/1",
                  bus.Timeout, dut.ptr_q, bus.Grant, dut.hold_q);
      end
      bus.Req = 4'b0000;
      step();
      n_cmp++;
      if (bus.Timeout !== 1'b0 || bus.Grant !== 4'b0000 || bus.Valid !== 1'b0) begin
         n_fail++;
         $display("FAIL to_pulse: to=%b grant=%b valid=%b, want 0/0000/0", bus.Timeout, bus.Grant, bus.Valid);
      end
   endtask

   task automatic test_ack_at_max();
      do_reset();
      bus.InA = 32'hA1;
      bus.Req = 4'b0010;
      for (int i = 1; i <= 15; i++) step();
      n_cmp++;
      if (bus.Grant !== 4'b0010 || dut.hold_q !== 4'd15) begin
         n_fail++;
         $display("FAIL ackmax_pre: grant=%b hold=%0d, want 0010/15", bus.Grant, dut.hold_q);
      end
      bus.Ack = 1'b1;
      bus.Req = 4'b0011;
      step();
      bus.Ack = 1'b0;
      n_cmp++;
      if (bus.Timeout !== 1'b0 || bus.Grant !== 4'b0001 || dut.ptr_q !== 2'd2 || bus.Out !== 32'hA1) begin
         n_fail++;
         $display("FAIL ackmax_rel: to=%b grant=%b ptr=%0d out=%h, want 0/0001/2/a1",
                  bus.Timeout, bus.Grant, dut.ptr_q, bus.Out);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_g [3] = '{4'b0001, 4'b1000, 4'b0001};
      do_reset();
      bus.Req = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         step();
         bus.Ack = 1'b1;
         n_cmp++;
         if (bus.Grant !== exp_g[i] || bus.Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL alt_%0d: grant=%b valid=%b, want %b/1", i, bus.Grant, bus.Valid, exp_g[i]);
         end
      end
      bus.Ack = 1'b0;
      bus.Req = 4'b1000;
      step();
      n_cmp++;
      if (bus.Grant !== 4'b1000 || bus.Timeout !== 1'b0 || dut.ptr_q !== 2'd1) begin
         n_fail++;
         $display("FAIL abandon: grant=%b to=%b ptr=%0d, want 1000/0/1", bus.Grant, bus.Timeout, dut.ptr_q);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.Req = 4'b0100;
      for (int i = 1; i <= 7; i++) step();
      n_cmp++;
      if (bus.Grant !== 4'b0100 || dut.hold_q !== 4'd7) begin
         n_fail++;
         $display("FAIL mid_pre: grant=%b hold=%0d, want 0100/7", bus.Grant, dut.hold_q);
      end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      n_cmp++;
      if (bus.Grant !== 4'b0000 || bus.Valid !== 1'b0 || bus.Timeout !== 1'b0 || bus.Sel !== 2'd0
          || bus.Out !== 32'h0 || dut.ptr_q !== 2'd0) begin
         n_fail++;
         $display("FAIL mid_reset: grant=%b valid=%b to=%b sel=%0d out=%h ptr=%0d, want all 0",
                  bus.Grant, bus.Valid, bus.Timeout, bus.Sel, bus.Out, dut.ptr_q);
      end
      step();
      n_cmp++;
      if (bus.Grant !== 4'b0100 || bus.Sel !== 2'd2) begin
         n_fail++;
         $display("FAIL mid_regrant: grant=%b sel=%0d, want 0100/2", bus.Grant, bus.Sel);
      end
   endtask

   task automatic test_nonowner();
      do_reset();
      bus.InA = 32'h5555_0000;
      bus.Req = 4'b0001;
      step();
      bus.Req = 4'b1111;
      bus.InA = 32'h5555_0001;
      step();
      n_cmp++;
      if (bus.Grant !== 4'b0001 || bus.Out !== 32'h5555_0001) begin
         n_fail++;
         $display("FAIL nonowner_1: grant=%b out=%h, want 0001/55550001", bus.Grant, bus.Out);
      end
      bus.Req = 4'b0011;
      bus.InA = 32'h5555_0002;
      step();
      n_cmp++;
      if (bus.Grant !== 4'b0001 || bus.Out !== 32'h5555_0002 || bus.Valid !== 1'b1) begin
         n_fail++;
         $display("FAIL nonowner_2: grant=%b out=%h valid=%b, want 0001/55550002/1",
                  bus.Grant, bus.Out, bus.Valid);
      end
   endtask

   initial begin
      n_cmp   = 0;
      n_fail  = 0;
      Reset   = 1'b1;
      bus.Req = 4'b0000;
      bus.Ack = 1'b0;
      bus.InA = '0;
      bus.InB = '0;
      bus.InC = '0;
      bus.InD = '0;
      #2;
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_ack_at_max();
      test_back_to_back();
      test_reset_mid();
      test_nonowner();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
